pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline-stage register, the successor to the fixed stall/bubble stage registers between our CPU pipeline stages. It carries an opaque payload bus plus commit and predicted-PC side fields. It replaces the global stall with a per-stage valid/ready handshake and adds an optional skid entry, so upstream ready never depends combinationally on downstream ready. Flush (bubble) is kept, and dropped entries are counted. It sits between any two stages, e.g. execute→memory.

---
 rtl/pipe_stage_elastic_if.sv | 31 +++
 rtl/pipe_stage_elastic.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle between two CPU pipeline stages: the upstream entry with its
// branch-resolution fields and the downstream head entry.
interface pipe_stage_elastic_if #(
   parameter int unsigned PAYLOAD_W = 144,
   parameter int unsigned PC_W      = 32
);
   logic                 up_valid_i;
   logic                 up_ready_o;
   logic [PAYLOAD_W-1:0] up_payload_i;
   logic                 up_commit_i;
   logic [PC_W-1:0]      up_pre_pc_i;
   logic                 up_cnd_i;
   logic [PC_W-1:0]      up_target_i;
   logic                 dn_valid_o;
   logic                 dn_ready_i;
   logic [PAYLOAD_W-1:0] dn_payload_o;
   logic                 dn_commit_o;
   logic [PC_W-1:0]      dn_pre_pc_o;

   modport slave (
      input  up_valid_i, up_payload_i, up_commit_i, up_pre_pc_i, up_cnd_i, up_target_i,
      input  dn_ready_i,
      output up_ready_o, dn_valid_o, dn_payload_o, dn_commit_o, dn_pre_pc_o
   );

   modport master (
      output up_valid_i, up_payload_i, up_commit_i, up_pre_pc_i, up_cnd_i, up_target_i,
      output dn_ready_i,
      input  up_ready_o, dn_valid_o, dn_payload_o, dn_commit_o, dn_pre_pc_o
   );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with optional skid entry, synchronous flush
// (bubble) and a saturating count of entries discarded by flush.
module pipe_stage_elastic #(
   parameter int unsigned PAYLOAD_W   = 144,
   parameter int unsigned PC_W        = 32,
   parameter bit          SKID_EN     = 1'b1,
   parameter int unsigned FLUSH_CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   flush_i,
   pipe_stage_elastic_if.slave    bus,
   output logic [1:0]             occupancy_o,
   output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);
   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic                 commit;
      logic [PC_W-1:0]      next_pc;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam entry_t ENTRY_CLR = {($bits(entry_t)){1'b0}};

   state_e                 state_r;
   entry_t                 main_r;
   entry_t                 skid_r;
   logic                   main_valid_r;
   logic                   skid_valid_r;
   logic [1:0]             occ_r;
   logic [FLUSH_CNT_W-1:0] flush_cnt_r;

   logic                   up_ready_s;
   logic                   up_fire_s;
   logic                   dn_fire_s;
   entry_t                 up_entry_s;
   logic [1:0]             flush_inc_s;

   function automatic logic [PC_W-1:0] sel_next_pc(input logic            cnd,
                                                   input logic [PC_W-1:0] target,
                                                   input logic [PC_W-1:0] pre_pc);
      if (cnd) begin
         return target;
      end else begin
         return pre_pc;
      end
   endfunction

   function automatic logic [FLUSH_CNT_W-1:0] sat_add(input logic [FLUSH_CNT_W-1:0] cnt,
                                                      input logic [1:0]             inc);
      logic [FLUSH_CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(FLUSH_CNT_W-1){1'b0}}, inc};
      if (sum[FLUSH_CNT_W]) begin
         return {FLUSH_CNT_W{1'b1}};
      end else begin
         return sum[FLUSH_CNT_W-1:0];
      end
   endfunction

   assign up_fire_s  = bus.up_valid_i & up_ready_s;
   assign dn_fire_s  = main_valid_r & bus.dn_ready_i;
   assign up_entry_s = {bus.up_payload_i, bus.up_commit_i,
                        sel_next_pc(bus.up_cnd_i, bus.up_target_i, bus.up_pre_pc_i)};
   // The head leaving in the flush cycle was taken by downstream, so it is not a loss.
   assign flush_inc_s = occ_r - {1'b0, dn_fire_s};

   // Upstream ready: skid variant looks only at held state, single-entry variant passes dn ready through.
   always_comb begin
      up_ready_s = 1'b0;
      if (flush_i) begin
         up_ready_s = 1'b0;
      end else if (SKID_EN) begin
         up_ready_s = ~skid_valid_r;
      end else begin
         up_ready_s = ~main_valid_r | bus.dn_ready_i;
      end
   end

   // Occupancy FSM holding the head and skid entries plus the flush-loss counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r      <= ST_EMPTY;
         main_r       <= ENTRY_CLR;
         skid_r       <= ENTRY_CLR;
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         occ_r        <= 2'd0;
         flush_cnt_r  <= {FLUSH_CNT_W{1'b0}};
      end else if (flush_i) begin
         state_r      <= ST_EMPTY;
         main_r       <= ENTRY_CLR;
         skid_r       <= ENTRY_CLR;
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         occ_r        <= 2'd0;
         flush_cnt_r  <= sat_add(flush_cnt_r, flush_inc_s);
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (up_fire_s) begin
                  main_r       <= up_entry_s;
                  main_valid_r <= 1'b1;
                  occ_r        <= 2'd1;
                  state_r      <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (up_fire_s && dn_fire_s) begin
                  main_r <= up_entry_s;
               end else if (up_fire_s) begin
                  // Only reachable with the skid entry: the younger entry parks behind the head.
                  skid_r       <= up_entry_s;
                  skid_valid_r <= 1'b1;
                  occ_r        <= 2'd2;
                  state_r      <= ST_FULL;
               end else if (dn_fire_s) begin
                  main_r       <= ENTRY_CLR;
                  main_valid_r <= 1'b0;
                  occ_r        <= 2'd0;
                  state_r      <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (dn_fire_s) begin
                  main_r       <= skid_r;
                  skid_r       <= ENTRY_CLR;
                  skid_valid_r <= 1'b0;
                  occ_r        <= 2'd1;
                  state_r      <= ST_ONE;
               end
            end
            default: begin
               state_r      <= ST_EMPTY;
               main_r       <= ENTRY_CLR;
               skid_r       <= ENTRY_CLR;
               main_valid_r <= 1'b0;
               skid_valid_r <= 1'b0;
               occ_r        <= 2'd0;
            end
         endcase
      end
   end

   assign bus.up_ready_o   = up_ready_s;
   assign bus.dn_valid_o   = main_valid_r;
   assign bus.dn_payload_o = main_r.payload;
   assign bus.dn_commit_o  = main_r.commit;
   assign bus.dn_pre_pc_o  = main_r.next_pc;
   assign occupancy_o      = occ_r;
   assign flush_cnt_o      = flush_cnt_r;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three instances (skid, no skid, skid with a narrow
// flush counter) share one stimulus and are compared against a FIFO-list model.
module tb_pipe_stage_elastic;
   localparam int PW = 144;
   localparam int AW = 32;

   typedef struct packed {
      logic [PW-1:0] pl;
      logic          cm;
      logic [AW-1:0] pc;
   } ent_t;

   logic          clk_i = 1'b0;
   logic          rst_n = 1'b1;
   logic          fl    = 1'b0;
   logic          uv    = 1'b0;
   logic [PW-1:0] upl   = {PW{1'b0}};
   logic          ucm   = 1'b0;
   logic [AW-1:0] upre  = {AW{1'b0}};
   logic          ucnd  = 1'b0;
   logic [AW-1:0] utgt  = {AW{1'b0}};
   logic          dr    = 1'b0;

   always #5 clk_i = ~clk_i;

   pipe_stage_elastic_if #(.PAYLOAD_W(PW), .PC_W(AW)) bus0 ();
   pipe_stage_elastic_if #(.PAYLOAD_W(PW), .PC_W(AW)) bus1 ();
   pipe_stage_elastic_if #(.PAYLOAD_W(PW), .PC_W(AW)) bus2 ();

   assign bus0.up_valid_i = uv;   assign bus1.up_valid_i = uv;   assign bus2.up_valid_i = uv;
   assign bus0.up_payload_i = upl; assign bus1.up_payload_i = upl; assign bus2.up_payload_i = upl;
   assign bus0.up_commit_i = ucm; assign bus1.up_commit_i = ucm; assign bus2.up_commit_i = ucm;
   assign bus0.up_pre_pc_i = upre; assign bus1.up_pre_pc_i = upre; assign bus2.up_pre_pc_i = upre;
   assign bus0.up_cnd_i = ucnd;   assign bus1.up_cnd_i = ucnd;   assign bus2.up_cnd_i = ucnd;
   assign bus0.up_target_i = utgt; assign bus1.up_target_i = utgt; assign bus2.up_target_i = utgt;
   assign bus0.dn_ready_i = dr;   assign bus1.dn_ready_i = dr;   assign bus2.dn_ready_i = dr;

   logic [1:0]  occ0, occ1, occ2;
   logic [15:0] cnt0, cnt1;
   logic [2:0]  cnt2;

   pipe_stage_elastic #(.PAYLOAD_W(PW), .PC_W(AW), .SKID_EN(1'b1), .FLUSH_CNT_W(16)) dut0 (
      .clk_i(clk_i), .rst_n_i(rst_n), .flush_i(fl), .bus(bus0),
      .occupancy_o(occ0), .flush_cnt_o(cnt0));
   pipe_stage_elastic #(.PAYLOAD_W(PW), .PC_W(AW), .SKID_EN(1'b0), .FLUSH_CNT_W(16)) dut1 (
      .clk_i(clk_i), .rst_n_i(rst_n), .flush_i(fl), .bus(bus1),
      .occupancy_o(occ1), .flush_cnt_o(cnt1));
   pipe_stage_elastic #(.PAYLOAD_W(PW), .PC_W(AW), .SKID_EN(1'b1), .FLUSH_CNT_W(3)) dut2 (
      .clk_i(clk_i), .rst_n_i(rst_n), .flush_i(fl), .bus(bus2),
      .occupancy_o(occ2), .flush_cnt_o(cnt2));

   logic          o_valid [3];
   logic          o_ready [3];
   logic [PW-1:0] o_pl    [3];
   logic          o_cm    [3];
   logic [AW-1:0] o_pc    [3];
   logic [1:0]    o_occ   [3];
   logic [15:0]   o_cnt   [3];

   assign o_valid[0] = bus0.dn_valid_o; assign o_valid[1] = bus1.dn_valid_o; assign o_valid[2] = bus2.dn_valid_o;
   assign o_ready[0] = bus0.up_ready_o; assign o_ready[1] = bus1.up_ready_o; assign o_ready[2] = bus2.up_ready_o;
   assign o_pl[0] = bus0.dn_payload_o;  assign o_pl[1] = bus1.dn_payload_o;  assign o_pl[2] = bus2.dn_payload_o;
   assign o_cm[0] = bus0.dn_commit_o;   assign o_cm[1] = bus1.dn_commit_o;   assign o_cm[2] = bus2.dn_commit_o;
   assign o_pc[0] = bus0.dn_pre_pc_o;   assign o_pc[1] = bus1.dn_pre_pc_o;   assign o_pc[2] = bus2.dn_pre_pc_o;
   assign o_occ[0] = occ0; assign o_occ[1] = occ1; assign o_occ[2] = occ2;
   assign o_cnt[0] = cnt0; assign o_cnt[1] = cnt1; assign o_cnt[2] = {13'd0, cnt2};

   // Model: each stage is an ordered list of at most 2 (skid) or 1 entries.
   ent_t m_ent  [3][2];
   int   m_n    [3];
   int   m_cnt  [3];
   int   m_max  [3];
   bit   m_skid [3];

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] mkpl(input int x);
      logic [31:0] v;
      v = x;
      return {v[15:0], 96'h0, v};
   endfunction

   function automatic bit exp_ready(input int k);
      if (fl) return 1'b0;
      if (m_skid[k]) return m_n[k] < 2;
      return (m_n[k] == 0) || (dr == 1'b1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_n[k]   = 0;
         m_cnt[k] = 0;
      end
   endtask

   task automatic model_step(input int k);
      bit   rdy, dnf, upf;
      ent_t e;
      rdy = exp_ready(k);
      dnf = (m_n[k] > 0) && (dr == 1'b1);
      upf = (uv == 1'b1) && rdy;
      e.pl = upl;
      e.cm = ucm;
      e.pc = ucnd ? utgt : upre;
      if (fl) begin
         m_cnt[k] = m_cnt[k] + m_n[k] - (dnf ? 1 : 0);
         if (m_cnt[k] > m_max[k]) m_cnt[k] = m_max[k];
         m_n[k] = 0;
      end else begin
         if (dnf) begin
            m_ent[k][0] = m_ent[k][1];
            m_n[k]--;
         end
         if (upf) begin
            m_ent[k][m_n[k]] = e;
            m_n[k]++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (!rst_n) model_reset();
      else for (int k = 0; k < 3; k++) model_step(k);
      #1;
   endtask

   task automatic push(input int x);
      uv   = 1'b1;
      upl  = mkpl(x);
      ucm  = x[0];
      upre = 32'h1000 + AW'(x * 4);
      ucnd = 1'b0;
      utgt = 32'h0;
   endtask

   task automatic idle();
      uv   = 1'b0;
      upl  = {PW{1'b0}};
      ucm  = 1'b0;
      upre = 32'h0;
      ucnd = 1'b0;
      utgt = 32'h0;
   endtask

   // Compare every instance against the model on each falling edge.
   initial begin
      forever begin
         @(negedge clk_i);
         if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
               ent_t h;
               h = (m_n[k] > 0) ? m_ent[k][0] : {($bits(ent_t)){1'b0}};
               chk($sformatf("d%0d.dn_valid", k), 160'(o_valid[k]), 160'(m_n[k] > 0));
               chk($sformatf("d%0d.up_ready", k), 160'(o_ready[k]), 160'(exp_ready(k)));
               chk($sformatf("d%0d.dn_payload", k), 160'(o_pl[k]), 160'(h.pl));
               chk($sformatf("d%0d.dn_commit", k), 160'(o_cm[k]), 160'(h.cm));
               chk($sformatf("d%0d.dn_pre_pc", k), 160'(o_pc[k]), 160'(h.pc));
               chk($sformatf("d%0d.occupancy", k), 160'(o_occ[k]), 160'(m_n[k]));
               chk($sformatf("d%0d.flush_cnt", k), 160'(o_cnt[k]), 160'(m_cnt[k]));
            end
         end
      end
   end

   initial begin
      m_skid[0] = 1'b1; m_skid[1] = 1'b0; m_skid[2] = 1'b1;
      m_max[0]  = 65535; m_max[1] = 65535; m_max[2] = 7;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("reset.up_ready", 160'(bus0.up_ready_o), 160'(1'b1));
      chk("reset.dn_valid", 160'(bus0.dn_valid_o), 160'(1'b0));
      chk("reset.occ", 160'(occ0), 160'(2'd0));
      chk("reset.cnt", 160'(cnt0), 160'(16'd0));
      chk_en = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;

      // Streaming with downstream always ready
      dr = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         push(i);
         tick();
         chk("stream.valid", 160'(bus0.dn_valid_o), 160'(1'b1));
         chk("stream.payload", 160'(bus0.dn_payload_o), 160'(mkpl(i)));
         chk("stream.occ", 160'(occ0), 160'(2'd1));
      end
      idle();
      tick();

      // Backpressure fills main and skid, third entry waits
      dr = 1'b0;
      push(10); tick();
      push(11); tick();
      chk("bp.occ_full", 160'(occ0), 160'(2'd2));
      chk("bp.ready_low", 160'(bus0.up_ready_o), 160'(1'b0));
      push(12); tick();
      chk("bp.hold_occ", 160'(occ0), 160'(2'd2));
      chk("bp.head_a", 160'(bus0.dn_payload_o), 160'(mkpl(10)));
      dr = 1'b1;
      tick();
      chk("bp.head_b", 160'(bus0.dn_payload_o), 160'(mkpl(11)));
      tick();
      chk("bp.head_c", 160'(bus0.dn_payload_o), 160'(mkpl(12)));
      idle();
      tick();
      chk("bp.drained", 160'(bus0.dn_valid_o), 160'(1'b0));

      // Redirect selects the target, otherwise the sequential PC
      uv = 1'b1; upl = mkpl(50); ucm = 1'b1; upre = 32'h104; ucnd = 1'b1; utgt = 32'h200;
      tick();
      chk("redir.taken", 160'(bus0.dn_pre_pc_o), 160'(32'h200));
      chk("redir.commit", 160'(bus0.dn_commit_o), 160'(1'b1));
      uv = 1'b1; upl = mkpl(51); ucm = 1'b0; upre = 32'h104; ucnd = 1'b0; utgt = 32'h200;
      tick();
      chk("redir.not_taken", 160'(bus0.dn_pre_pc_o), 160'(32'h104));
      idle();
      tick();

      // Single-entry stage: ready follows dn_ready in the same cycle
      dr = 1'b0;
      push(20); tick();
      chk("noskid.occ", 160'(occ1), 160'(2'd1));
      push(21);
      #1;
      chk("noskid.ready_low", 160'(bus1.up_ready_o), 160'(1'b0));
      dr = 1'b1;
      #1;
      chk("noskid.ready_pass", 160'(bus1.up_ready_o), 160'(1'b1));
      tick();
      chk("noskid.replace", 160'(bus1.dn_payload_o), 160'(mkpl(21)));
      idle();
      tick();
      tick();

      // Flush while full, incoming entry refused
      dr = 1'b0;
      push(30); tick();
      push(31); tick();
      push(32); fl = 1'b1;
      #1;
      chk("flush.ready_gate", 160'(bus0.up_ready_o), 160'(1'b0));
      tick();
      fl = 1'b0;
      chk("flush.valid", 160'(bus0.dn_valid_o), 160'(1'b0));
      chk("flush.payload", 160'(bus0.dn_payload_o), 160'(1'b0));
      chk("flush.pc", 160'(bus0.dn_pre_pc_o), 160'(1'b0));
      chk("flush.occ", 160'(occ0), 160'(2'd0));
      chk("flush.cnt_skid", 160'(cnt0), 160'(16'd2));
      chk("flush.cnt_noskid", 160'(cnt1), 160'(16'd1));
      chk("flush.cnt_narrow", 160'(cnt2), 160'(3'd2));

      // Repeated full flushes saturate the narrow counter
      for (int r = 0; r < 6; r++) begin
         push(60 + r); tick();
         push(61 + r); tick();
         fl = 1'b1; tick();
         fl = 1'b0;
      end
      idle();
      chk("sat.narrow", 160'(cnt2), 160'(3'd7));
      chk("sat.skid", 160'(cnt0), 160'(16'd14));
      chk("sat.noskid", 160'(cnt1), 160'(16'd7));

      // Head taken by downstream in the flush cycle is not counted
      push(70); tick();
      push(71); tick();
      dr = 1'b1; fl = 1'b1; tick();
      fl = 1'b0; dr = 1'b0;
      idle();
      chk("flushdn.skid", 160'(cnt0), 160'(16'd15));
      chk("flushdn.noskid", 160'(cnt1), 160'(16'd7));
      tick();

      // Asynchronous reset between edges
      push(80); tick();
      push(81);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset.valid", 160'(bus0.dn_valid_o), 160'(1'b0));
      chk("areset.occ", 160'(occ0), 160'(2'd0));
      chk("areset.cnt", 160'(cnt0), 160'(16'd0));
      chk("areset.ready", 160'(bus0.up_ready_o), 160'(1'b1));
      model_reset();
      tick();
      rst_n = 1'b1;
      dr = 1'b1;
      push(82); tick();
      chk("post_reset.payload", 160'(bus0.dn_payload_o), 160'(mkpl(82)));
      idle();
      tick();
      tick();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
